// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: byte stream -> big-endian words at BASE_ADDR.
// Define IM_LOADER_CKSUM_EN to require a trailing XOR checksum byte before DONE.
module im_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [12:0] word_cnt
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE
`ifdef IM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  n_hi_reg, n_hi_next;
    logic [12:0] n_reg, n_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [23:0] word_reg, word_next;
    logic        im_we_reg, im_we_next;
    logic [31:0] im_addr_reg, im_addr_next;
    logic [31:0] im_wdata_reg, im_wdata_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [12:0] word_cnt_reg, word_cnt_next;
`ifdef IM_LOADER_CKSUM_EN
    logic [7:0]  cksum_reg, cksum_next;
`endif

    logic        accept;
    logic [15:0] hdr_n;

    assign in_ready = (state_reg == S_HDR0) || (state_reg == S_HDR1) ||
`ifdef IM_LOADER_CKSUM_EN
                      (state_reg == S_CKSUM) ||
`endif
                      (state_reg == S_DATA);
    assign busy     = in_ready;
    assign accept   = in_valid && in_ready;
    assign hdr_n    = {n_hi_reg, in_data};

    assign im_we    = im_we_reg;
    assign im_addr  = im_addr_reg;
    assign im_wdata = im_wdata_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign word_cnt = word_cnt_reg;

    always_comb begin
        state_next    = state_reg;
        n_hi_next     = n_hi_reg;
        n_next        = n_reg;
        byte_cnt_next = byte_cnt_reg;
        word_next     = word_reg;
        im_we_next    = 1'b0;
        im_addr_next  = im_addr_reg;
        im_wdata_next = im_wdata_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        word_cnt_next = word_cnt_reg;
`ifdef IM_LOADER_CKSUM_EN
        cksum_next    = cksum_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_HDR0;
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                    word_cnt_next = '0;
                    byte_cnt_next = '0;
`ifdef IM_LOADER_CKSUM_EN
                    cksum_next    = '0;
`endif
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_hi_next  = in_data;
                    state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if ({1'b0, hdr_n} > DEPTH_L) begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end else if (hdr_n == 16'd0) begin
`ifdef IM_LOADER_CKSUM_EN
                        state_next = S_CKSUM;
`else
                        state_next = S_DONE;
                        done_next  = 1'b1;
`endif
                    end else begin
                        n_next     = hdr_n[12:0];
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef IM_LOADER_CKSUM_EN
                    cksum_next    = cksum_reg ^ in_data;
`endif
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        // Address is taken from the pre-increment count: word k lives at BASE + 4k.
                        im_we_next    = 1'b1;
                        im_wdata_next = {word_reg, in_data};
                        im_addr_next  = BASE_ADDR + (32'(word_cnt_reg) << 2);
                        word_cnt_next = word_cnt_reg + 13'd1;
                        if (word_cnt_reg + 13'd1 == n_reg) begin
`ifdef IM_LOADER_CKSUM_EN
                            state_next = S_CKSUM;
`else
                            state_next = S_DONE;
                            done_next  = 1'b1;
`endif
                        end
                    end else begin
                        word_next = {word_reg[15:0], in_data};
                    end
                end
            end
`ifdef IM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (accept) begin
                    if (in_data == cksum_reg) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            n_hi_reg     <= '0;
            n_reg        <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            im_we_reg    <= 1'b0;
            im_addr_reg  <= '0;
            im_wdata_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            word_cnt_reg <= '0;
`ifdef IM_LOADER_CKSUM_EN
            cksum_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            n_hi_reg     <= n_hi_next;
            n_reg        <= n_next;
            byte_cnt_reg <= byte_cnt_next;
            word_reg     <= word_next;
            im_we_reg    <= im_we_next;
            im_addr_reg  <= im_addr_next;
            im_wdata_reg <= im_wdata_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            word_cnt_reg <= word_cnt_next;
`ifdef IM_LOADER_CKSUM_EN
            cksum_reg    <= cksum_next;
`endif
        end
    end

endmodule
